// File: rtl/pc8e_reader_pkg.sv
// Shared constants for the PC8E high-speed reader: IOT decode fields,
// major-state codes and the receiver state encoding.
package pc8e_reader_pkg;

  localparam logic [4:0] MS_IOT  = 5'd0;
  localparam logic [2:0] OP_IOT  = 3'o6;
  localparam logic [5:0] DEV_RDR = 6'o01;
  localparam logic [5:0] DEV_PCE = 6'o02;

  // Function field of a reader IOT; RSF/RRB/RFC are single bits and combine.
  localparam logic [2:0] FN_RPE = 3'd0;
  localparam logic [2:0] FN_RSF = 3'd1;
  localparam logic [2:0] FN_RRB = 3'd2;
  localparam logic [2:0] FN_RFC = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/pc8e_reader_if.sv
// CPU I/O path as seen by the reader: IOT request in, bus/skip/irq back.
interface pc8e_reader_if;
  logic [4:0]  state;
  logic [0:11] instruction;
  logic        UF;
  logic [0:11] reader_bus;
  logic        skip;
  logic        interrupt;

  modport master (output state, instruction, UF, input reader_bus, skip, interrupt);
  modport slave  (input state, instruction, UF, output reader_bus, skip, interrupt);
endinterface

// File: rtl/pc8e_reader_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module pc8e_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pc8e_reader.sv
// PC8E high-speed paper-tape reader: 8N1 deserialiser feeding a FIFO, with
// bytes handed to the CPU one per RFC through the IOT interface.
module pc8e_reader
  import pc8e_reader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [4:0]  IOT_STATE    = MS_IOT,
  parameter logic [5:0]  DEV          = DEV_RDR
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  pc8e_reader_if.slave  bus,
  input  logic          rx_tape,
  output logic          overrun,
  output logic          frm_err
);
  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  logic [2:0]  fn;
  logic        iot_ok, iot_q, iot_edge, rdr_sel, pce_sel;
  logic        do_rpe, do_rsf, do_rrb, do_rfc;
  logic [7:0]  rb;
  logic        flag, int_en, fetch_pend;
  logic        rx_meta, rx_s;
  rx_state_t   rx_st, rx_st_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        rx_push, rx_ferr;
  logic        fifo_full, fifo_empty, pop;
  logic [7:0]  fifo_dout;

  assign fn       = bus.instruction[9:11];
  assign iot_ok   = (bus.state == IOT_STATE) && (bus.instruction[0:2] == OP_IOT) && !bus.UF;
  assign rdr_sel  = iot_ok && (bus.instruction[3:8] == DEV);
  assign pce_sel  = iot_ok && (bus.instruction[3:8] == DEV_PCE) && (fn == FN_RPE);
  assign iot_edge = iot_ok & ~iot_q;
  assign do_rpe   = rdr_sel && (fn == FN_RPE);
  assign do_rsf   = rdr_sel && |(fn & FN_RSF);
  assign do_rrb   = rdr_sel && |(fn & FN_RRB);
  assign do_rfc   = rdr_sel && |(fn & FN_RFC);

  assign bus.reader_bus = do_rrb ? {4'b0000, rb} : 12'o0000;
  assign bus.skip       = do_rsf & flag;
  assign bus.interrupt  = flag & int_en;

  // Pops wait out the IOT edge cycle so the flag set lands after any RRB clear.
  assign pop = fetch_pend & ~fifo_empty & ~iot_edge & ~clear;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iot_q      <= 1'b0;
      rb         <= '0;
      flag       <= 1'b0;
      int_en     <= 1'b0;
      fetch_pend <= 1'b0;
      overrun    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      iot_q <= iot_ok;
      if (clear) begin
        flag       <= 1'b0;
        int_en     <= 1'b0;
        fetch_pend <= 1'b0;
        overrun    <= 1'b0;
        frm_err    <= 1'b0;
      end else begin
        if (iot_edge && do_rpe)  int_en <= 1'b1;
        if (iot_edge && pce_sel) int_en <= 1'b0;
        if (pop) begin
          rb         <= fifo_dout;
          flag       <= 1'b1;
          fetch_pend <= 1'b0;
        end else begin
          if (iot_edge && (do_rrb || do_rfc)) flag <= 1'b0;
          if (iot_edge && do_rfc) fetch_pend <= 1'b1;
        end
        if (rx_push && fifo_full && !pop) overrun <= 1'b1;
        if (rx_ferr) frm_err <= 1'b1;
      end
    end
  end

  // Receiver: two-flop synchroniser, then mid-bit sampling FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_st   <= RX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx_tape;
      rx_s    <= rx_meta;
      rx_st   <= rx_st_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    rx_st_n   = rx_st;
    baud_n    = baud + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    rx_push   = 1'b0;
    rx_ferr   = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        baud_n = '0;
        if (!rx_s) rx_st_n = RX_START;
      end
      RX_START: begin
        if (baud == HALF_LAST) begin
          baud_n    = '0;
          bit_idx_n = '0;
          rx_st_n   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud == BIT_LAST) begin
          baud_n    = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) rx_st_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud == BIT_LAST) begin
          baud_n  = '0;
          rx_push = rx_s;
          rx_ferr = ~rx_s;
          rx_st_n = rx_s ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        baud_n = '0;
        if (rx_s) rx_st_n = RX_IDLE;
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  pc8e_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (clear),
    .push   (rx_push),
    .pop    (pop),
    .din    (shreg),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_pc8e_reader.sv
// Directed bench for pc8e_reader: serial bytes in, IOT reads out, checked
// against a byte-queue model of the FIFO and RB.
module tb_pc8e_reader;
  import pc8e_reader_pkg::*;

  localparam int         CPB     = 16;
  localparam logic [4:0] IDLE_ST = 5'd1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clear = 1'b0;
  logic rx_tape = 1'b1;
  logic overrun, frm_err;

  pc8e_reader_if cpu ();

  pc8e_reader #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .IOT_STATE    (5'd0),
    .DEV          (6'o01)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (clear),
    .bus     (cpu),
    .rx_tape (rx_tape),
    .overrun (overrun),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_m [$];
  logic [7:0] rb_m = 8'h00;
  bit         pend_m = 1'b0;
  bit         abort_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_try_pop();
    if (pend_m && fifo_m.size() > 0) begin
      rb_m   = fifo_m.pop_front();
      pend_m = 1'b0;
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (fifo_m.size() < 4) fifo_m.push_back(b);
    model_try_pop();
  endtask

  task automatic iot(input logic [11:0] code, input bit uf,
                     output logic [11:0] rbus, output logic sk);
    @(negedge clk);
    cpu.state       = 5'd0;
    cpu.instruction = code;
    cpu.UF          = uf;
    #1;
    rbus = cpu.reader_bus;
    sk   = cpu.skip;
    @(negedge clk);
    cpu.state       = IDLE_ST;
    cpu.instruction = '0;
    cpu.UF          = 1'b0;
    if (!uf && code[11:3] == 9'o601 && code[2]) begin
      pend_m = 1'b1;
      model_try_pop();
    end
  endtask

  task automatic iot0(input logic [11:0] code);
    logic [11:0] b;
    logic        s;
    iot(code, 1'b0, b, s);
  endtask

  task automatic rrb(input string tag, input logic [11:0] code);
    logic [11:0] b;
    logic        s;
    logic [7:0]  exp;
    exp = rb_m;
    iot(code, 1'b0, b, s);
    chk(tag, b, {4'h0, exp});
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    @(negedge clk);
    rx_tape = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_tape = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_tape = good;
    repeat (CPB) @(negedge clk);
    rx_tape = 1'b1;
    repeat (2) @(negedge clk);
    if (good && !abort_m) model_push(b);
  endtask

  task automatic wait_int(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu.interrupt) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    fifo_m.delete();
    pend_m = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] b;
    logic        s;
    bit          seen;

    cpu.state       = IDLE_ST;
    cpu.instruction = '0;
    cpu.UF          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_skip", cpu.skip, 0);
    chk("rst_int",  cpu.interrupt, 0);
    chk("rst_bus",  cpu.reader_bus, 0);
    chk("rst_ovr",  overrun, 0);
    chk("rst_ferr", frm_err, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic fetch of one byte.
    iot(12'o6011, 1'b0, b, s);
    chk("rsf_skip0", s, 0);
    chk("rsf_bus0", b, 0);
    iot0(12'o6010);
    iot0(12'o6014);
    chk("idle_int", cpu.interrupt, 0);
    send_frame(8'h5A, 1'b1);
    wait_int(8, seen);
    chk("flag_5a", seen, 1);
    iot(12'o6012, 1'b0, b, s);
    chk("rrb_5a", b, 12'o0132);
    rb_m = 8'h5A;
    chk("rrb_clr", cpu.interrupt, 0);

    // Buffered bytes, RFC timing, RRB+RFC chaining.
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    chk("no_rfc", cpu.interrupt, 0);
    iot0(12'o6014);
    chk("rfc_edge", cpu.interrupt, 0);
    @(negedge clk);
    chk("rfc_plus1", cpu.interrupt, 1);
    iot(12'o6011, 1'b0, b, s);
    chk("rsf_skip1", s, 1);
    rrb("rrbf_1", 12'o6016);
    rrb("rrbf_2", 12'o6016);
    rrb("rrb_3", 12'o6012);

    // Overflow: six bytes into four slots.
    for (int i = 0; i < 6; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1);
      if (i == 3) chk("ovr_pre", overrun, 0);
      if (i == 4) chk("ovr_set", overrun, 1);
    end
    for (int k = 0; k < 4; k++) begin
      iot0(12'o6014);
      wait_int(8, seen);
      chk("ovr_fetch", seen, 1);
      rrb("ovr_rrb", 12'o6012);
    end
    iot0(12'o6014);
    wait_int(20, seen);
    chk("fifth_pend", seen, 0);
    do_clear();
    chk("clr_ovr", overrun, 0);
    iot0(12'o6010);
    send_frame(8'h21, 1'b1);
    wait_int(8, seen);
    chk("clr_pend", seen, 0);
    iot0(12'o6014);
    wait_int(8, seen);
    chk("fetch_21", seen, 1);
    rrb("rrb_21", 12'o6012);

    // Framing error, then glitch rejection.
    send_frame(8'hFF, 1'b0);
    chk("ferr_set", frm_err, 1);
    iot0(12'o6014);
    send_frame(8'h33, 1'b1);
    wait_int(8, seen);
    chk("fetch_33", seen, 1);
    rrb("rrb_33", 12'o6012);
    @(negedge clk);
    rx_tape = 1'b0;
    repeat (4) @(negedge clk);
    rx_tape = 1'b1;
    repeat (40) @(negedge clk);
    iot0(12'o6014);
    wait_int(30, seen);
    chk("glitch", seen, 0);
    send_frame(8'h44, 1'b1);
    wait_int(8, seen);
    chk("fetch_44", seen, 1);
    rrb("rrb_44", 12'o6012);

    // User mode blocks IOTs; PCE/RPE toggle the interrupt enable.
    iot(12'o6014, 1'b1, b, s);
    iot(12'o6012, 1'b1, b, s);
    chk("uf_bus", b, 0);
    send_frame(8'h55, 1'b1);
    wait_int(10, seen);
    chk("uf_nofetch", seen, 0);
    iot0(12'o6014);
    wait_int(8, seen);
    chk("fetch_55", seen, 1);
    iot0(12'o6020);
    chk("pce", cpu.interrupt, 0);
    iot0(12'o6010);
    chk("rpe", cpu.interrupt, 1);
    rrb("rrb_55", 12'o6012);

    // Clear flushes the FIFO and cancels a pending fetch mid-byte.
    send_frame(8'h77, 1'b1);
    do_clear();
    iot0(12'o6010);
    iot0(12'o6014);
    wait_int(20, seen);
    chk("flush", seen, 0);
    fork
      send_frame(8'h66, 1'b1);
      begin
        repeat (60) @(negedge clk);
        do_clear();
      end
    join
    chk("clr_int", cpu.interrupt, 0);
    iot0(12'o6010);
    wait_int(10, seen);
    chk("clr_fetch", seen, 0);
    iot0(12'o6014);
    wait_int(8, seen);
    chk("fetch_66", seen, 1);
    rrb("rrb_66", 12'o6012);

    // Asynchronous reset in the middle of a byte.
    iot0(12'o6014);
    send_frame(8'h12, 1'b1);
    wait_int(8, seen);
    chk("pre_rst_int", seen, 1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (50) @(negedge clk);
        #2;
        resetn  = 1'b0;
        abort_m = 1'b1;
        #1;
        chk("async_int", cpu.interrupt, 0);
        chk("async_ovr", overrun, 0);
      end
    join
    @(negedge clk);
    resetn  = 1'b1;
    abort_m = 1'b0;
    fifo_m.delete();
    pend_m = 1'b0;
    rb_m   = 8'h00;
    iot0(12'o6010);
    iot0(12'o6014);
    wait_int(20, seen);
    chk("rst_nopush", seen, 0);
    send_frame(8'h7E, 1'b1);
    wait_int(8, seen);
    chk("fetch_7e", seen, 1);
    rrb("rrb_7e", 12'o6012);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
